// File: rtl/axil2apb_if.sv
// AXI4-Lite slave / APB master signal bundle for the axil2apb bridge.
// AXIL2APB_SLVERR_EN adds apb_slverr_i (APB PSLVERR) to the bundle.
interface axil2apb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned WSTRB_W = DATA_W / 8;

  logic [ADDR_W-1:0]  axil_awaddr_i;
  logic               axil_awvalid_i;
  logic               axil_awready_o;
  logic [DATA_W-1:0]  axil_wdata_i;
  logic [WSTRB_W-1:0] axil_wstrb_i;
  logic               axil_wvalid_i;
  logic               axil_wready_o;
  logic [1:0]         axil_bresp_o;
  logic               axil_bvalid_o;
  logic               axil_bready_i;
  logic [ADDR_W-1:0]  axil_araddr_i;
  logic               axil_arvalid_i;
  logic               axil_arready_o;
  logic [DATA_W-1:0]  axil_rdata_o;
  logic [1:0]         axil_rresp_o;
  logic               axil_rvalid_o;
  logic               axil_rready_i;
  logic               apb_sel_o;
  logic               apb_enable_o;
  logic [ADDR_W-1:0]  apb_addr_o;
  logic               apb_write_o;
  logic [DATA_W-1:0]  apb_wdata_o;
  logic [WSTRB_W-1:0] apb_wstrb_o;
  logic [DATA_W-1:0]  apb_rdata_i;
  logic               apb_ready_i;
`ifdef AXIL2APB_SLVERR_EN
  logic               apb_slverr_i;
`endif

  // Bridge side: AXI-Lite slave, APB master.
  modport slave (
`ifdef AXIL2APB_SLVERR_EN
    input  apb_slverr_i,
`endif
    input  axil_awaddr_i, axil_awvalid_i, axil_wdata_i, axil_wstrb_i, axil_wvalid_i,
    input  axil_bready_i, axil_araddr_i, axil_arvalid_i, axil_rready_i,
    input  apb_rdata_i, apb_ready_i,
    output axil_awready_o, axil_wready_o, axil_bresp_o, axil_bvalid_o,
    output axil_arready_o, axil_rdata_o, axil_rresp_o, axil_rvalid_o,
    output apb_sel_o, apb_enable_o, apb_addr_o, apb_write_o, apb_wdata_o, apb_wstrb_o
  );

  // Environment side: AXI-Lite master and APB slave.
  modport master (
`ifdef AXIL2APB_SLVERR_EN
    output apb_slverr_i,
`endif
    output axil_awaddr_i, axil_awvalid_i, axil_wdata_i, axil_wstrb_i, axil_wvalid_i,
    output axil_bready_i, axil_araddr_i, axil_arvalid_i, axil_rready_i,
    output apb_rdata_i, apb_ready_i,
    input  axil_awready_o, axil_wready_o, axil_bresp_o, axil_bvalid_o,
    input  axil_arready_o, axil_rdata_o, axil_rresp_o, axil_rvalid_o,
    input  apb_sel_o, apb_enable_o, apb_addr_o, apb_write_o, apb_wdata_o, apb_wstrb_o
  );
endinterface

// File: rtl/axil2apb.sv
// AXI4-Lite slave to APB master bridge: 1-deep AW/W/AR buffers, round-robin
// read/write arbitration, one APB transfer at a time. AXIL2APB_SLVERR_EN maps PSLVERR to SLVERR.
module axil2apb #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic        clk_i,
  input  logic        cke_i,
  input  logic        arst_i,
  axil2apb_if.slave   bus
);
  localparam int unsigned WSTRB_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RESP_W, RESP_R} state_t;

  state_t               state_q, state_d;
  logic                 aw_full_q, aw_full_d, w_full_q, w_full_d, ar_full_q, ar_full_d;
  logic [ADDR_W-1:0]    awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [WSTRB_W-1:0]   wstrb_q, wstrb_d;
  logic                 last_wr_q, last_wr_d;
  logic                 sel_q, sel_d, en_q, en_d, write_q, write_d;
  logic [ADDR_W-1:0]    paddr_q, paddr_d;
  logic [DATA_W-1:0]    pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic [WSTRB_W-1:0]   pstrb_q, pstrb_d;
  logic [1:0]           resp_q, resp_d;
  logic                 bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic                 wr_pend, rd_pend, grant_wr;

  assign wr_pend  = aw_full_q & w_full_q;
  assign rd_pend  = ar_full_q;
  // Ties go to the channel not served last.
  assign grant_wr = wr_pend & (~rd_pend | ~last_wr_q);

  always_comb begin
    state_d   = state_q;
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    ar_full_d = ar_full_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    last_wr_d = last_wr_q;
    write_d   = write_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;

    if (bus.axil_awvalid_i && !aw_full_q) begin
      aw_full_d = 1'b1;
      awaddr_d  = bus.axil_awaddr_i;
    end
    if (bus.axil_wvalid_i && !w_full_q) begin
      w_full_d = 1'b1;
      wdata_d  = bus.axil_wdata_i;
      wstrb_d  = bus.axil_wstrb_i;
    end
    if (bus.axil_arvalid_i && !ar_full_q) begin
      ar_full_d = 1'b1;
      araddr_d  = bus.axil_araddr_i;
    end

    unique case (state_q)
      IDLE: begin
        if (wr_pend || rd_pend) begin
          state_d   = SETUP;
          last_wr_d = grant_wr;
          write_d   = grant_wr;
          paddr_d   = grant_wr ? awaddr_q : araddr_q;
          pwdata_d  = grant_wr ? wdata_q : '0;
          pstrb_d   = grant_wr ? wstrb_q : '0;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (bus.apb_ready_i) begin
          state_d = write_q ? RESP_W : RESP_R;
          if (!write_q) rdata_d = bus.apb_rdata_i;
`ifdef AXIL2APB_SLVERR_EN
          resp_d = bus.apb_slverr_i ? 2'b10 : 2'b00;
`endif
        end
      end
      RESP_W: begin
        if (bus.axil_bready_i) begin
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      RESP_R: begin
        if (bus.axil_rready_i) begin
          ar_full_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of what the next state requires.
    sel_d    = (state_d == SETUP) || (state_d == ACCESS);
    en_d     = (state_d == ACCESS);
    bvalid_d = (state_d == RESP_W);
    rvalid_d = (state_d == RESP_R);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= IDLE;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      ar_full_q <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      last_wr_q <= 1'b1;
      sel_q     <= 1'b0;
      en_q      <= 1'b0;
      write_q   <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
    end else if (cke_i) begin
      state_q   <= state_d;
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      ar_full_q <= ar_full_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      last_wr_q <= last_wr_d;
      sel_q     <= sel_d;
      en_q      <= en_d;
      write_q   <= write_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign bus.axil_awready_o = ~aw_full_q;
  assign bus.axil_wready_o  = ~w_full_q;
  assign bus.axil_arready_o = ~ar_full_q;
  assign bus.axil_bresp_o   = resp_q;
  assign bus.axil_bvalid_o  = bvalid_q;
  assign bus.axil_rdata_o   = rdata_q;
  assign bus.axil_rresp_o   = resp_q;
  assign bus.axil_rvalid_o  = rvalid_q;
  assign bus.apb_sel_o      = sel_q;
  assign bus.apb_enable_o   = en_q;
  assign bus.apb_addr_o     = paddr_q;
  assign bus.apb_write_o    = write_q;
  assign bus.apb_wdata_o    = pwdata_q;
  assign bus.apb_wstrb_o    = pstrb_q;
endmodule

// File: doc/axil2apb.md
Name: axil2apb

Overview:
- AXI4-Lite slave to APB master bridge; the stage directly upstream of the APB-to-IOb bridge.
- Lets an AXI-Lite interconnect port drive an APB segment whose slaves are IOb peripherals behind apb2iob.
- Buffers one AW, one W and one AR beat, arbitrates reads against writes and runs one APB SETUP/ACCESS transfer at a time.
- Returns the B or R response to the AXI-Lite master.

Parameters:
- ADDR_W, 32, address width in bits (AXI-Lite and APB).
- DATA_W, 32, data width in bits; must be a multiple of 8; WSTRB_W = DATA_W/8.

Ports:
- clk_i  in  1  system clock
- cke_i  in  1  clock enable; when low, all registers hold
- arst_i  in  1  reset, asynchronous, active-high
- axil_awaddr_i  in  ADDR_W  write address
- axil_awvalid_i  in  1  write address valid
- axil_awready_o  out  1  write address ready
- axil_wdata_i  in  DATA_W  write data
- axil_wstrb_i  in  WSTRB_W  write byte strobes
- axil_wvalid_i  in  1  write data valid
- axil_wready_o  out  1  write data ready
- axil_bresp_o  out  2  write response
- axil_bvalid_o  out  1  write response valid
- axil_bready_i  in  1  write response ready
- axil_araddr_i  in  ADDR_W  read address
- axil_arvalid_i  in  1  read address valid
- axil_arready_o  out  1  read address ready
- axil_rdata_o  out  DATA_W  read data
- axil_rresp_o  out  2  read response
- axil_rvalid_o  out  1  read data valid
- axil_rready_i  in  1  read data ready
- apb_sel_o  out  1  APB PSEL
- apb_enable_o  out  1  APB PENABLE
- apb_addr_o  out  ADDR_W  APB PADDR
- apb_write_o  out  1  APB PWRITE
- apb_wdata_o  out  DATA_W  APB PWDATA
- apb_wstrb_o  out  WSTRB_W  APB PSTRB
- apb_rdata_i  in  DATA_W  APB PRDATA
- apb_ready_i  in  1  APB PREADY

Behaviour:
- One clock, clk_i. arst_i is asynchronous and active-high. cke_i gates every register.
- Reset values: all outputs 0, all buffers empty, FSM in IDLE, last_grant = WRITE.
- Input buffers:
  - AW, W and AR each have a 1-deep holding register with a full flag.
  - awready = !aw_full; wready = !w_full; arready = !ar_full. All three are combinational from the flags.
  - A buffer captures on its valid&ready edge.
  - A write buffer clears only on the B handshake; the AR buffer clears only on the R handshake.
  - AW and W may arrive in either order or in the same cycle.
- FSM states: IDLE, SETUP, ACCESS, RESP_W, RESP_R.
- IDLE:
  - wr_pend = aw_full & w_full; rd_pend = ar_full.
  - If both are pending, grant the opposite of last_grant (round-robin). After reset the first tie grants READ.
  - On grant: load apb_addr/write/wdata/wstrb. Reads drive apb_wstrb_o = 0 and apb_wdata_o = 0.
  - Update last_grant and go to SETUP.
- SETUP: apb_sel=1, apb_enable=0 for exactly one cycle, then ACCESS.
- ACCESS:
  - apb_sel=1, apb_enable=1; address, data and control held stable.
  - Stays in ACCESS while apb_ready_i=0. No timeout.
  - On apb_ready_i=1:
    - Write: go to RESP_W.
    - Read: capture apb_rdata_i into axil_rdata_o and go to RESP_R.
  - On leaving ACCESS, apb_sel and apb_enable drop to 0 in the next cycle.
- RESP_W: bvalid=1, bresp=OKAY(2'b00). On bready: clear the AW and W buffers, go to IDLE.
- RESP_R: rvalid=1, rresp=OKAY. On rready: clear the AR buffer, go to IDLE.
- Outputs:
  - APB outputs are registered. apb_addr_o, apb_wdata_o, apb_wstrb_o and apb_write_o hold their last values while idle.
  - axil_rdata_o holds its value until the next read capture.
- Latency: with AW+W accepted in cycle 0 and apb_ready_i=1 on the first ACCESS cycle:
  - IDLE grants in cycle 1.
  - SETUP in cycle 2.
  - ACCESS in cycle 3.
  - bvalid in cycle 4.
- Simultaneous events:
  - A new AR arriving while a write is in flight is buffered. It is served after the B handshake unless another complete write is pending and last_grant=READ.
  - A second AW cannot be accepted until the first B completes.
- Only one APB transfer is outstanding at any time. apb_sel_o never rises while bvalid or rvalid is high.
- Reset mid-transfer: apb_sel/apb_enable drop asynchronously, buffers empty, responses dropped; no recovery of the lost transaction.

Optional Feature:
- Macro: AXIL2APB_SLVERR_EN.
- When defined:
  - Adds port apb_slverr_i (in, 1, APB PSLVERR), sampled together with apb_ready_i in ACCESS.
  - Registers it into bresp/rresp as SLVERR (2'b10) when high, OKAY otherwise.
  - Read data is still captured on error.
- When undefined: the port is absent and responses are always OKAY.

Test Plan:
- AW=0x10 and W=0xDEADBEEF/strb 0xF in the same cycle, apb_ready_i=1 -> SETUP, then ACCESS with paddr=0x10, pwrite=1, pstrb=0xF; bvalid in cycle 4; bresp=00.
- W first, AW 3 cycles later, strb 0x3 -> no APB activity until AW arrives; then pstrb=0x3, one write transfer.
- AR 0x20, apb_ready_i low for 5 ACCESS cycles, prdata=0x12345678 -> enable held 5+1 cycles; rdata=0x12345678; rvalid held until rready.
- After reset, complete write and AR presented in the same cycle -> read transfer first, then write; next tie -> write granted.
- rready held low 4 cycles -> no new APB transfer, arready=0; then clean return to IDLE.
- With AXIL2APB_SLVERR_EN, slverr=1 on a write -> bresp=2'b10; arst_i asserted mid-ACCESS -> sel/enable=0 immediately, all valids 0.
